// File: rtl/pulse_burst_gen.sv
// Burst generator: emits burstLen single-cycle pulses separated by gapCycles low cycles, then done.
// Optional abort input is enabled by defining PULSE_BURST_ABORT_EN.
module pulse_burst_gen #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burstLen,
    input  logic [GAP_W-1:0] gapCycles,
`ifdef PULSE_BURST_ABORT_EN
    input  logic             abort,
`endif
    output logic             pulseOut,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             abort_req;

`ifdef PULSE_BURST_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            gap_reg_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_reg_q   <= gap_reg_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_reg_d   = gap_reg_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (burstLen != '0) begin
                        remaining_d = burstLen;
                        gap_reg_d   = gapCycles;
                        state_d     = StPulse;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StPulse: begin
                remaining_d = remaining_q - CNT_W'(1);
                if (abort_req) begin
                    state_d = StDone;
                end else if (remaining_q == CNT_W'(1)) begin
                    state_d = StDone;
                end else if (gap_reg_q != '0) begin
                    gap_cnt_d = gap_reg_q;
                    state_d   = StGap;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (abort_req) begin
                    state_d = StDone;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = StPulse;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode the state register directly, so they change only on edges (or reset).
    assign pulseOut = (state_q == StPulse);
    assign busy     = (state_q == StPulse) || (state_q == StGap);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen; expected traces come from the burst timing formulas.
module tb_pulse_burst_gen;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 8;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] burstLen = '0;
    logic [GAP_W-1:0] gapCycles = '0;
    logic             abort = 1'b0;
    logic             pulseOut, busy, done;

    int n_checks = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    pulse_burst_gen #(
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (start),
        .burstLen (burstLen),
        .gapCycles(gapCycles),
`ifdef PULSE_BURST_ABORT_EN
        .abort    (abort),
`endif
        .pulseOut (pulseOut),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: {pulse,busy,done} got %b want %b", tag, obs, exp);
    endtask

    // Cycle c counts clock edges after the one that accepted start (c=1 is first cycle after).
    function automatic logic [2:0] expect_at(int c, int n, int g, int abort_at);
        int last;
        logic p, b, d;
        if (n == 0) return (c == 1) ? 3'b001 : 3'b000;
        last = 1 + (n - 1) * (g + 1);
        if (abort_at > 0 && abort_at < last) last = abort_at;
        b = (c >= 1) && (c <= last);
        p = b && ((c - 1) % (g + 1) == 0);
        d = (c == last + 1);
        return {p, b, d};
    endfunction

    task automatic run_burst(input int n, input int g, input int restart_at, input int abort_at,
                             input string tag);
        int last, ncyc;
        @(negedge Clk);
        start     = 1'b1;
        burstLen  = CNT_W'(n);
        gapCycles = GAP_W'(g);
        @(posedge Clk);
        #1;
        start     = 1'b0;
        // Scramble the config inputs; the accepted burst must not notice.
        burstLen  = ~CNT_W'(n);
        gapCycles = ~GAP_W'(g);
        if (n == 0) begin
            ncyc = 2;
        end else begin
            last = 1 + (n - 1) * (g + 1);
            if (abort_at > 0 && abort_at < last) last = abort_at;
            ncyc = last + 2;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge Clk);
            check($sformatf("%s c%0d", tag, c), {pulseOut, busy, done},
                  expect_at(c, n, g, abort_at));
            if (c == restart_at) begin
                start    = 1'b1;
                burstLen = CNT_W'(5);
            end else begin
                start = 1'b0;
            end
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // Asynchronous reset between edges
        #3 Rst = 1'b0;
        #1 check("reset_async", {pulseOut, busy, done}, 3'b000);
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check($sformatf("idle c%0d", i), {pulseOut, busy, done}, 3'b000);
        end

        run_burst(3, 2, 0, 0, "nominal");
        run_burst(0, 7, 0, 0, "zero_len");
        run_burst(4, 0, 0, 0, "zero_gap");
        run_burst(2, 3, 3, 0, "busy_ignore");
        run_burst(15, 255, 0, 0, "max");

        // Reset mid-burst: N=5, G=1, reset during cycle 4
        @(negedge Clk);
        start     = 1'b1;
        burstLen  = CNT_W'(5);
        gapCycles = GAP_W'(1);
        @(posedge Clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            check($sformatf("rst_mid c%0d", c), {pulseOut, busy, done}, expect_at(c, 5, 1, 0));
        end
        Rst = 1'b0;
        #1 check("rst_mid async", {pulseOut, busy, done}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check($sformatf("rst_mid hold%0d", i), {pulseOut, busy, done}, 3'b000);
        end
        Rst = 1'b1;
        run_burst(1, 0, 0, 0, "after_rst");

`ifdef PULSE_BURST_ABORT_EN
        run_burst(6, 1, 0, 4, "abort");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
